// File: rtl/writeback_stage.sv
// Final pipeline stage: registers MEM results, extracts load data and selects the register-file write data.
// Optional feature: define WRITEBACK_STAGE_INSTRET_EN to add the 64-bit retired-instruction counter o_instret.
module writeback_stage #(
   parameter int DATA_SIZE = 32,
   parameter int INST_SIZE = 32,
   parameter int NUM_REGS  = 32,
   localparam int RW = $clog2(NUM_REGS)
) (
   input  logic                 i_aclk,
   input  logic                 i_areset_n,
   input  logic                 i_stall,
   input  logic                 i_flush,
   input  logic                 i_valid,
   input  logic [RW-1:0]        i_rdest,
   input  logic                 i_cu_regwrite,
   input  logic [1:0]           i_cu_wbsel,
   input  logic [2:0]           i_ld_funct3,
   input  logic [1:0]           i_addr_lsb,
   input  logic [INST_SIZE-1:0] i_pcplus4,
   input  logic [DATA_SIZE-1:0] i_mem_data,
   input  logic [DATA_SIZE-1:0] i_exe_data,
   input  logic [DATA_SIZE-1:0] i_csr_data,
   output logic                 o_valid,
   output logic [RW-1:0]        o_rdest,
   output logic                 o_cu_regwrite,
   output logic [DATA_SIZE-1:0] o_wb_result,
`ifdef WRITEBACK_STAGE_INSTRET_EN
   output logic [63:0]          o_instret,
`endif
   output logic                 o_misalign
);

   logic                 valid;
   logic                 regwrite;
   logic [RW-1:0]        rdest;
   logic [1:0]           wbsel;
   logic [2:0]           funct3;
   logic [1:0]           addr_lsb;
   logic [INST_SIZE-1:0] pcplus4;
   logic [DATA_SIZE-1:0] mem_data;
   logic [DATA_SIZE-1:0] exe_data;
   logic [DATA_SIZE-1:0] csr_data;

   // Flush only kills the valid bit; the payload is left as-is since nothing qualifies it without valid.
   always_ff @(posedge i_aclk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         valid    <= 1'b0;
         regwrite <= 1'b0;
         rdest    <= '0;
         wbsel    <= '0;
         funct3   <= '0;
         addr_lsb <= '0;
         pcplus4  <= '0;
         mem_data <= '0;
         exe_data <= '0;
         csr_data <= '0;
      end else if (i_flush) begin
         valid <= 1'b0;
      end else if (!i_stall) begin
         valid    <= i_valid;
         regwrite <= i_cu_regwrite;
         rdest    <= i_rdest;
         wbsel    <= i_cu_wbsel;
         funct3   <= i_ld_funct3;
         addr_lsb <= i_addr_lsb;
         pcplus4  <= i_pcplus4;
         mem_data <= i_mem_data;
         exe_data <= i_exe_data;
         csr_data <= i_csr_data;
      end
   end

   logic [31:0]          load_word;
   logic [31:0]          shifted_word;
   logic [7:0]           load_byte;
   logic [15:0]          load_half;
   logic [DATA_SIZE-1:0] load_data;
   logic                 load_reserved;

   always_comb begin
      load_word     = mem_data[31:0];
      shifted_word  = load_word >> {addr_lsb, 3'b000};
      load_byte     = shifted_word[7:0];
      load_half     = addr_lsb[1] ? load_word[31:16] : load_word[15:0];
      load_data     = '0;
      load_reserved = 1'b0;
      case (funct3)
         3'b000: begin
            load_data       = {DATA_SIZE{load_byte[7]}};
            load_data[7:0]  = load_byte;
         end
         3'b001: begin
            load_data       = {DATA_SIZE{load_half[15]}};
            load_data[15:0] = load_half;
         end
         3'b010: begin
            load_data       = {DATA_SIZE{load_word[31]}};
            load_data[31:0] = load_word;
         end
         3'b100: load_data[7:0]  = load_byte;
         3'b101: load_data[15:0] = load_half;
         default: load_reserved  = 1'b1;
      endcase
   end

   logic                 is_load;
   logic                 misalign;
   logic [DATA_SIZE-1:0] result;

   always_comb begin
      is_load  = (wbsel == 2'b01);
      misalign = valid & is_load &
                 ((((funct3 == 3'b001) | (funct3 == 3'b101)) & addr_lsb[0]) |
                  ((funct3 == 3'b010) & (addr_lsb != 2'b00)));
      result   = '0;
      case (wbsel)
         2'b00: result = exe_data;
         2'b01: result = load_data;
         2'b10: result[INST_SIZE-1:0] = pcplus4;
         default: result = csr_data;
      endcase
   end

   assign o_valid       = valid;
   assign o_rdest       = rdest;
   assign o_wb_result   = result;
   assign o_misalign    = misalign;
   assign o_cu_regwrite = valid & regwrite & (rdest != '0) & ~misalign & ~(is_load & load_reserved);

`ifdef WRITEBACK_STAGE_INSTRET_EN
   logic [63:0] instret;
   logic        retire;

   // An instruction retires only on the cycle it leaves the stage, so a stalled one is counted once.
   assign retire = valid & (~i_stall | i_flush) & ~misalign;

   always_ff @(posedge i_aclk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         instret <= '0;
      end else if (retire) begin
         instret <= instret + 64'd1;
      end
   end

   assign o_instret = instret;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage with hand-computed expected values.
// Checks o_instret as well when WRITEBACK_STAGE_INSTRET_EN is defined.
module tb_writeback_stage;

   logic        i_aclk;
   logic        i_areset_n;
   logic        i_stall;
   logic        i_flush;
   logic        i_valid;
   logic [4:0]  i_rdest;
   logic        i_cu_regwrite;
   logic [1:0]  i_cu_wbsel;
   logic [2:0]  i_ld_funct3;
   logic [1:0]  i_addr_lsb;
   logic [31:0] i_pcplus4;
   logic [31:0] i_mem_data;
   logic [31:0] i_exe_data;
   logic [31:0] i_csr_data;
   logic        o_valid;
   logic [4:0]  o_rdest;
   logic        o_cu_regwrite;
   logic [31:0] o_wb_result;
   logic        o_misalign;
`ifdef WRITEBACK_STAGE_INSTRET_EN
   logic [63:0] o_instret;
`endif

   int compare_count = 0;
   int fail_count    = 0;

   // Retire model: tracks the instruction the bench believes is in the stage.
   logic        m_valid = 1'b0;
   logic        m_mis   = 1'b0;
   logic [63:0] exp_instret = 64'd0;
   logic [63:0] instret_before;

   writeback_stage dut (
      .i_aclk        (i_aclk),
      .i_areset_n    (i_areset_n),
      .i_stall       (i_stall),
      .i_flush       (i_flush),
      .i_valid       (i_valid),
      .i_rdest       (i_rdest),
      .i_cu_regwrite (i_cu_regwrite),
      .i_cu_wbsel    (i_cu_wbsel),
      .i_ld_funct3   (i_ld_funct3),
      .i_addr_lsb    (i_addr_lsb),
      .i_pcplus4     (i_pcplus4),
      .i_mem_data    (i_mem_data),
      .i_exe_data    (i_exe_data),
      .i_csr_data    (i_csr_data),
      .o_valid       (o_valid),
      .o_rdest       (o_rdest),
      .o_cu_regwrite (o_cu_regwrite),
      .o_wb_result   (o_wb_result),
`ifdef WRITEBACK_STAGE_INSTRET_EN
      .o_instret     (o_instret),
`endif
      .o_misalign    (o_misalign)
   );

   initial i_aclk = 1'b0;
   always #5 i_aclk = ~i_aclk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compare_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic rw,
                                input logic [1:0] ws, input logic [2:0] f3, input logic [1:0] lsb,
                                input logic [31:0] pc, input logic [31:0] mem,
                                input logic [31:0] exe, input logic [31:0] csr, input logic mis);
      i_valid       = v;
      i_rdest       = rd;
      i_cu_regwrite = rw;
      i_cu_wbsel    = ws;
      i_ld_funct3   = f3;
      i_addr_lsb    = lsb;
      i_pcplus4     = pc;
      i_mem_data    = mem;
      i_exe_data    = exe;
      i_csr_data    = csr;
      if (m_valid && !m_mis && (!i_stall || i_flush)) exp_instret = exp_instret + 64'd1;
      if (i_flush) m_valid = 1'b0;
      else if (!i_stall) begin
         m_valid = v;
         m_mis   = mis;
      end
      @(posedge i_aclk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_valid"}, {63'd0, o_valid}, 64'd0);
      checkOutput({tag, "_rdest"}, {59'd0, o_rdest}, 64'd0);
      checkOutput({tag, "_regwrite"}, {63'd0, o_cu_regwrite}, 64'd0);
      checkOutput({tag, "_result"}, {32'd0, o_wb_result}, 64'd0);
      checkOutput({tag, "_misalign"}, {63'd0, o_misalign}, 64'd0);
`ifdef WRITEBACK_STAGE_INSTRET_EN
      checkOutput({tag, "_instret"}, o_instret, 64'd0);
`endif
   endtask

   task automatic checkWrite(input string tag, input logic [4:0] rd, input logic we,
                             input logic [31:0] res, input logic mis);
      checkOutput({tag, "_rdest"}, {59'd0, o_rdest}, {59'd0, rd});
      checkOutput({tag, "_regwrite"}, {63'd0, o_cu_regwrite}, {63'd0, we});
      checkOutput({tag, "_result"}, {32'd0, o_wb_result}, {32'd0, res});
      checkOutput({tag, "_misalign"}, {63'd0, o_misalign}, {63'd0, mis});
   endtask

   initial begin
      i_areset_n    = 1'b0;
      i_stall       = 1'b0;
      i_flush       = 1'b0;
      i_valid       = 1'b0;
      i_rdest       = '0;
      i_cu_regwrite = 1'b0;
      i_cu_wbsel    = '0;
      i_ld_funct3   = '0;
      i_addr_lsb    = '0;
      i_pcplus4     = '0;
      i_mem_data    = '0;
      i_exe_data    = '0;
      i_csr_data    = '0;

      #12;
      checkAllZero("reset");
      i_areset_n = 1'b1;
      #4;

      applyStimulus(1, 5, 1, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h1234_5678, 32'h0, 0);
      checkOutput("alu_valid", {63'd0, o_valid}, 64'd1);
      checkWrite("alu", 5'd5, 1'b1, 32'h1234_5678, 1'b0);

      applyStimulus(1, 6, 1, 2'b01, 3'b000, 2'b11, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 0);
      checkWrite("lb_lane3", 5'd6, 1'b1, 32'hFFFF_FF80, 1'b0);
      applyStimulus(1, 6, 1, 2'b01, 3'b100, 2'b11, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 0);
      checkWrite("lbu_lane3", 5'd6, 1'b1, 32'h0000_0080, 1'b0);
      applyStimulus(1, 6, 1, 2'b01, 3'b101, 2'b10, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 0);
      checkWrite("lhu_hi", 5'd6, 1'b1, 32'h0000_80FF, 1'b0);
      applyStimulus(1, 7, 1, 2'b01, 3'b000, 2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 0);
      checkWrite("lb_lane1", 5'd7, 1'b1, 32'h0000_007F, 1'b0);
      applyStimulus(1, 7, 1, 2'b01, 3'b001, 2'b00, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 0);
      checkWrite("lh_lo", 5'd7, 1'b1, 32'h0000_7F01, 1'b0);
      applyStimulus(1, 7, 1, 2'b01, 3'b001, 2'b10, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 0);
      checkWrite("lh_hi", 5'd7, 1'b1, 32'hFFFF_80FF, 1'b0);
      applyStimulus(1, 8, 1, 2'b01, 3'b010, 2'b00, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 0);
      checkWrite("lw", 5'd8, 1'b1, 32'h80FF_7F01, 1'b0);

      applyStimulus(1, 8, 1, 2'b01, 3'b010, 2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 1);
      checkOutput("lw_mis_flag", {63'd0, o_misalign}, 64'd1);
      checkOutput("lw_mis_regwrite", {63'd0, o_cu_regwrite}, 64'd0);
      applyStimulus(1, 8, 1, 2'b01, 3'b101, 2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 1);
      checkOutput("lhu_mis_flag", {63'd0, o_misalign}, 64'd1);
`ifdef WRITEBACK_STAGE_INSTRET_EN
      checkOutput("mis_instret", o_instret, exp_instret);
      checkOutput("mis_instret_count", exp_instret, 64'd8);
`endif
      applyStimulus(1, 9, 1, 2'b00, 3'b010, 2'b01, 32'h0, 32'h0, 32'hCAFE_0001, 32'h0, 0);
      checkWrite("alu_no_mis", 5'd9, 1'b1, 32'hCAFE_0001, 1'b0);

      applyStimulus(1, 9, 1, 2'b01, 3'b011, 2'b00, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 0);
      checkWrite("reserved_ld", 5'd9, 1'b0, 32'h0, 1'b0);

      applyStimulus(1, 0, 1, 2'b10, 3'b000, 2'b00, 32'h104, 32'h0, 32'h0, 32'h0, 0);
      checkWrite("jal_x0", 5'd0, 1'b0, 32'h104, 1'b0);
      applyStimulus(1, 10, 1, 2'b11, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 0);
      checkWrite("csr", 5'd10, 1'b1, 32'hDEAD_BEEF, 1'b0);
      applyStimulus(0, 11, 1, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h1111_2222, 32'h0, 0);
      checkOutput("bubble_valid", {63'd0, o_valid}, 64'd0);
      checkOutput("bubble_regwrite", {63'd0, o_cu_regwrite}, 64'd0);

      applyStimulus(1, 9, 1, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'hAAAA_0001, 32'h0, 0);
      instret_before = exp_instret;
      i_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, 12, 1, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h5555_0000 + k, 32'h0, 0);
         checkWrite("stall_hold", 5'd9, 1'b1, 32'hAAAA_0001, 1'b0);
         checkOutput("stall_valid", {63'd0, o_valid}, 64'd1);
      end
      i_stall = 1'b0;
      applyStimulus(0, 13, 0, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 0);
      checkOutput("stall_release_valid", {63'd0, o_valid}, 64'd0);
      checkOutput("stall_retire_once", exp_instret, instret_before + 64'd1);
`ifdef WRITEBACK_STAGE_INSTRET_EN
      checkOutput("stall_instret", o_instret, exp_instret);
`endif

      applyStimulus(1, 14, 1, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0000_00BB, 32'h0, 0);
      checkOutput("pre_flush_valid", {63'd0, o_valid}, 64'd1);
      i_stall = 1'b1;
      i_flush = 1'b1;
      applyStimulus(1, 15, 1, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0000_00CC, 32'h0, 0);
      checkOutput("flush_stall_valid", {63'd0, o_valid}, 64'd0);
      checkOutput("flush_stall_regwrite", {63'd0, o_cu_regwrite}, 64'd0);
`ifdef WRITEBACK_STAGE_INSTRET_EN
      checkOutput("flush_instret", o_instret, exp_instret);
`endif
      i_stall = 1'b0;
      i_flush = 1'b0;

      applyStimulus(1, 3, 1, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0000_0077, 32'h0, 0);
      checkWrite("pre_reset", 5'd3, 1'b1, 32'h0000_0077, 1'b0);
      i_stall = 1'b1;
      #2;
      i_areset_n = 1'b0;
      #1;
      checkAllZero("mid_reset");
      m_valid     = 1'b0;
      m_mis       = 1'b0;
      exp_instret = 64'd0;
      @(posedge i_aclk);
      #1;
      checkAllZero("held_reset");
      i_areset_n = 1'b1;
      i_stall    = 1'b0;
      #2;

      applyStimulus(1, 4, 1, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0BAD_F00D, 32'h0, 0);
      checkWrite("post_reset", 5'd4, 1'b1, 32'h0BAD_F00D, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
      $finish;
   end

endmodule
